// File: rtl/ram_bist_ctrl.sv
// March-style BIST initiator for a small synchronous RAM: write/read background,
// write/read inverted background, with mismatch count and first failing address.
module ram_bist_ctrl #(
   parameter int                ADDR_W  = 4,
   parameter int                DATA_W  = 2,
   parameter logic [DATA_W-1:0] PATTERN = 2'b01
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W+1:0] err_count,
   output logic [ADDR_W-1:0] fail_addr,
   output logic              ram_we,
   output logic              ram_oe,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, FLUSH} state_t;

   localparam logic [ADDR_W-1:0] LAST = '1;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr, addr_nxt;
   logic                cmp_vld;
   logic [DATA_W-1:0]   cmp_exp;
   logic [ADDR_W-1:0]   cmp_addr;
   logic                first_fail;
   logic                rd_issue;
   logic                mismatch;
   logic [ADDR_W+1:0]   err_nxt;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Each phase ends on the edge where the counter sits at its terminal
   // value; the counter is preloaded for the direction of the next phase.
   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      unique case (state)
         IDLE: begin
            addr_nxt = '0;
            if (start) state_nxt = WR0;
         end
         WR0: begin
            if (addr == LAST) begin state_nxt = RD0; addr_nxt = '0; end
            else addr_nxt = addr + ADDR_W'(1);
         end
         RD0: begin
            if (addr == LAST) begin state_nxt = WR1; addr_nxt = LAST; end
            else addr_nxt = addr + ADDR_W'(1);
         end
         WR1: begin
            if (addr == '0) begin state_nxt = RD1; addr_nxt = LAST; end
            else addr_nxt = addr - ADDR_W'(1);
         end
         RD1: begin
            if (addr == '0) begin state_nxt = FLUSH; addr_nxt = '0; end
            else addr_nxt = addr - ADDR_W'(1);
         end
         FLUSH: begin
            state_nxt = IDLE;
            addr_nxt  = '0;
         end
         default: begin
            state_nxt = IDLE;
            addr_nxt  = '0;
         end
      endcase
      if (state != IDLE && abort) begin
         state_nxt = IDLE;
         addr_nxt  = '0;
      end
   end

   assign busy     = (state != IDLE);
   assign ram_oe   = busy;
   assign ram_we   = (state == WR0) || (state == WR1);
   assign ram_addr = addr;
   assign ram_din  = (state == WR0) ? PATTERN :
                     (state == WR1) ? ~PATTERN : '0;

   assign rd_issue = (state == RD0) || (state == RD1);
   assign mismatch = cmp_vld && (ram_dout != cmp_exp);
   assign err_nxt  = err_count + (ADDR_W+2)'(mismatch);

   // Read data arrives one cycle after the address, so the expected value
   // and address ride along in a one-stage compare register.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr       <= '0;
         cmp_vld    <= 1'b0;
         cmp_exp    <= '0;
         cmp_addr   <= '0;
         err_count  <= '0;
         fail_addr  <= '0;
         first_fail <= 1'b0;
         pass       <= 1'b0;
         done       <= 1'b0;
      end else begin
         addr     <= addr_nxt;
         done     <= 1'b0;
         cmp_vld  <= rd_issue && !abort;
         cmp_exp  <= (state == RD0) ? PATTERN : ~PATTERN;
         cmp_addr <= addr;
         if (state == IDLE) begin
            if (start) begin
               err_count  <= '0;
               fail_addr  <= '0;
               first_fail <= 1'b0;
               pass       <= 1'b0;
            end
         end else if (abort) begin
            pass <= 1'b0;
         end else begin
            if (mismatch) begin
               err_count <= err_nxt;
               if (!first_fail) begin
                  fail_addr  <= cmp_addr;
                  first_fail <= 1'b1;
               end
            end
            if (state == FLUSH) begin
               done <= 1'b1;
               pass <= (err_nxt == '0);
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural 16x2 RAM with stuck-at and read-glitch
// injection, op-sequence scoreboard, and a march model for expected results.
module tb_ram_bist_ctrl;

   localparam logic [1:0] PAT = 2'b01;

   typedef struct packed {logic we; logic [3:0] addr; logic [1:0] din;} op_t;
   typedef struct packed {logic [5:0] err; logic [3:0] fa; logic pass;} res_t;

   logic       clk = 1'b0;
   logic       rst, start, abort;
   logic       busy, done, pass;
   logic [5:0] err_count;
   logic [3:0] fail_addr;
   logic       ram_we, ram_oe;
   logic [3:0] ram_addr;
   logic [1:0] ram_din, ram_dout;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int glitch_at = -1;
   int glitch_k = -1;

   op_t  op_q[$];
   res_t res_q[$];
   op_t  mon_e;

   logic [1:0] mem [16] = '{default: '0};
   logic [1:0] sa0 [16] = '{default: '0};
   logic [1:0] sa1 [16] = '{default: '0};
   logic [1:0] dout_q = '0;

   ram_bist_ctrl #(.ADDR_W(4), .DATA_W(2), .PATTERN(PAT)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_addr(fail_addr),
      .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // RAM: registered read, faults applied on the read path
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_we) mem[ram_addr] <= ram_din;
      else if (ram_oe) dout_q <= (mem[ram_addr] & ~sa0[ram_addr]) | sa1[ram_addr];
   end
   assign ram_dout = dout_q ^ ((glitch_at >= 0 && cyc == glitch_at) ? 2'b11 : 2'b00);

   // scoreboard: one expected RAM op per cycle while a run is armed
   always @(negedge clk) begin
      if (op_q.size() > 0) begin
         mon_e = op_q.pop_front();
         checks++;
         if (ram_we !== mon_e.we || ram_addr !== mon_e.addr || busy !== 1'b1 ||
             ram_oe !== 1'b1 || (mon_e.we && ram_din !== mon_e.din)) begin
            errors++;
            $display("FAIL ram_op: got we=%b addr=%0d din=%b busy=%b oe=%b, want we=%b addr=%0d din=%b busy=1 oe=1",
                     ram_we, ram_addr, ram_din, busy, ram_oe, mon_e.we, mon_e.addr, mon_e.din);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // called in the cycle after the start edge: queue the op sequence and
   // the expected final result from an independent march model
   task automatic arm();
      op_t  o;
      res_t r;
      int   e = 0;
      int   fa = 0;
      bit   got = 0;
      logic [1:0] obs;
      glitch_at = (glitch_k >= 0) ? cyc + glitch_k : -1;
      for (int i = 0; i < 16; i++) begin o.we = 1; o.addr = 4'(i);    o.din = PAT;  op_q.push_back(o); end
      for (int i = 0; i < 16; i++) begin o.we = 0; o.addr = 4'(i);    o.din = 2'b00; op_q.push_back(o); end
      for (int i = 0; i < 16; i++) begin o.we = 1; o.addr = 4'(15-i); o.din = ~PAT; op_q.push_back(o); end
      for (int i = 0; i < 16; i++) begin o.we = 0; o.addr = 4'(15-i); o.din = 2'b00; op_q.push_back(o); end
      for (int i = 0; i < 16; i++) begin
         obs = ((PAT & ~sa0[i]) | sa1[i]) ^ ((glitch_k == 17 + i) ? 2'b11 : 2'b00);
         if (obs != PAT) begin e++; if (!got) begin fa = i; got = 1; end end
      end
      for (int i = 0; i < 16; i++) begin
         obs = ((~PAT & ~sa0[15-i]) | sa1[15-i]) ^ ((glitch_k == 49 + i) ? 2'b11 : 2'b00);
         if (obs != ~PAT) begin e++; if (!got) begin fa = 15 - i; got = 1; end end
      end
      r.err = 6'(e); r.fa = 4'(fa); r.pass = (e == 0);
      res_q.push_back(r);
   endtask

   task automatic launch(input bit hold);
      start = 1'b1;
      tick();
      if (!hold) start = 1'b0;
      arm();
   endtask

   task automatic wait_done(output int n, output int b);
      n = 0;
      b = 0;
      while (done !== 1'b1 && n < 100) begin
         if (busy === 1'b1) b++;
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({busy, done, pass, ram_we, ram_oe} !== 5'b0 || err_count !== 6'd0 ||
          fail_addr !== 4'd0 || ram_addr !== 4'd0 || ram_din !== 2'b00) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b pass=%b we=%b oe=%b err=%0d fa=%0d addr=%0d din=%b, want all 0",
                  busy, done, pass, ram_we, ram_oe, err_count, fail_addr, ram_addr, ram_din);
      end
      rst = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL idle_abort: busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   task automatic test_fault_free();
      int n, b;
      res_t r;
      bit bad = 0;
      glitch_k = -1;
      launch(0);
      wait_done(n, b);
      checks++;
      if (n !== 65) begin errors++; $display("FAIL clean_done_cycle: got %0d want 65", n); end
      checks++;
      if (b !== 65) begin errors++; $display("FAIL clean_busy_cycles: got %0d want 65", b); end
      r = res_q.pop_front();
      checks++;
      if ({err_count, fail_addr, pass} !== r) begin
         errors++;
         $display("FAIL clean_result: got err=%0d fa=%0d pass=%b want err=%0d fa=%0d pass=%b",
                  err_count, fail_addr, pass, r.err, r.fa, r.pass);
      end
      for (int i = 0; i < 16; i++) if (mem[i] !== ~PAT) bad = 1;
      checks++;
      if (bad) begin errors++; $display("FAIL clean_ram_final: some location not %b", ~PAT); end
      tick();
      checks++;
      if (done !== 1'b0 || pass !== 1'b1) begin
         errors++;
         $display("FAIL done_pulse_width: done=%b pass=%b want 0 1", done, pass);
      end
   endtask

   task automatic test_stuck(input int a0, input logic [1:0] m0, input int a1, input logic [1:0] m1);
      int n, b;
      res_t r;
      glitch_k = -1;
      sa0[a0] = m0;
      sa1[a1] = m1;
      launch(0);
      wait_done(n, b);
      checks++;
      if (n !== 65) begin errors++; $display("FAIL stuck_done_cycle: got %0d want 65", n); end
      r = res_q.pop_front();
      checks++;
      if ({err_count, fail_addr, pass} !== r) begin
         errors++;
         $display("FAIL stuck_result: got err=%0d fa=%0d pass=%b want err=%0d fa=%0d pass=%b",
                  err_count, fail_addr, pass, r.err, r.fa, r.pass);
      end
      sa0[a0] = 2'b00;
      sa1[a1] = 2'b00;
   endtask

   task automatic test_abort();
      int n, b;
      int dcnt = 0;
      res_t r;
      glitch_k = -1;
      launch(0);
      repeat (24) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      op_q.delete();
      res_q.delete();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_count !== 6'd0) begin
         errors++;
         $display("FAIL abort_state: busy=%b done=%b pass=%b err=%0d want 0 0 0 0", busy, done, pass, err_count);
      end
      repeat (5) begin tick(); if (done === 1'b1) dcnt++; end
      checks++;
      if (dcnt !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", dcnt); end
      launch(0);
      wait_done(n, b);
      checks++;
      if (n !== 65) begin errors++; $display("FAIL after_abort_done: got %0d want 65", n); end
      r = res_q.pop_front();
      checks++;
      if ({err_count, fail_addr, pass} !== r) begin
         errors++;
         $display("FAIL after_abort_result: got err=%0d fa=%0d pass=%b want err=%0d fa=%0d pass=%b",
                  err_count, fail_addr, pass, r.err, r.fa, r.pass);
      end
   endtask

   task automatic test_reset_mid();
      int dcnt = 0;
      int first = -1;
      res_t r;
      glitch_k = -1;
      launch(0);
      repeat (40) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      op_q.delete();
      res_q.delete();
      checks++;
      if ({busy, done, pass, ram_we, ram_oe} !== 5'b0 || err_count !== 6'd0 ||
          fail_addr !== 4'd0 || ram_addr !== 4'd0 || ram_din !== 2'b00) begin
         errors++;
         $display("FAIL reset_mid_state: busy=%b done=%b pass=%b we=%b oe=%b err=%0d fa=%0d addr=%0d din=%b, want all 0",
                  busy, done, pass, ram_we, ram_oe, err_count, fail_addr, ram_addr, ram_din);
      end
      launch(0);
      for (int c = 0; c < 80; c++) begin
         if (done === 1'b1) begin dcnt++; if (first < 0) first = c; end
         start = (c == 5 || c == 20 || c == 50);
         tick();
      end
      start = 1'b0;
      checks++;
      if (dcnt !== 1 || first !== 65) begin
         errors++;
         $display("FAIL busy_start_ignored: got %0d done pulses first at %0d want 1 at 65", dcnt, first);
      end
      r = res_q.pop_front();
      checks++;
      if ({err_count, fail_addr, pass} !== r) begin
         errors++;
         $display("FAIL busy_start_result: got err=%0d fa=%0d pass=%b want err=%0d fa=%0d pass=%b",
                  err_count, fail_addr, pass, r.err, r.fa, r.pass);
      end
   endtask

   task automatic test_boundary(input int k);
      int n, b;
      res_t r;
      glitch_k = k;
      launch(0);
      wait_done(n, b);
      glitch_k = -1;
      glitch_at = -1;
      checks++;
      if (n !== 65) begin errors++; $display("FAIL boundary_done_cycle k=%0d: got %0d want 65", k, n); end
      r = res_q.pop_front();
      checks++;
      if ({err_count, fail_addr, pass} !== r) begin
         errors++;
         $display("FAIL boundary_result k=%0d: got err=%0d fa=%0d pass=%b want err=%0d fa=%0d pass=%b",
                  k, err_count, fail_addr, pass, r.err, r.fa, r.pass);
      end
   endtask

   task automatic test_back_to_back();
      int n, b;
      res_t r;
      glitch_k = -1;
      launch(1);
      wait_done(n, b);
      checks++;
      if (n !== 65) begin errors++; $display("FAIL b2b_first_done: got %0d want 65", n); end
      r = res_q.pop_front();
      checks++;
      if ({err_count, fail_addr, pass} !== r) begin
         errors++;
         $display("FAIL b2b_first_result: got err=%0d fa=%0d pass=%b want err=%0d fa=%0d pass=%b",
                  err_count, fail_addr, pass, r.err, r.fa, r.pass);
      end
      tick();
      arm();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_restart: busy=%b done=%b want 1 0", busy, done);
      end
      wait_done(n, b);
      checks++;
      if (n !== 65) begin errors++; $display("FAIL b2b_second_done: got %0d want 65", n); end
      r = res_q.pop_front();
      checks++;
      if ({err_count, fail_addr, pass} !== r) begin
         errors++;
         $display("FAIL b2b_second_result: got err=%0d fa=%0d pass=%b want err=%0d fa=%0d pass=%b",
                  err_count, fail_addr, pass, r.err, r.fa, r.pass);
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      test_reset();
      test_fault_free();
      test_stuck(3, 2'b01, 0, 2'b00);
      test_stuck(12, 2'b10, 5, 2'b01);
      test_abort();
      test_reset_mid();
      test_boundary(32);
      test_boundary(64);
      test_back_to_back();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
